// File: rtl/cpu16_isa_pkg.sv
// cpu16_isa_pkg: shared ISA encodings, ALU codes and the decoded micro-op type
package cpu16_isa_pkg;
  localparam logic [3:0] OP_RR  = 4'b0000;
  localparam logic [3:0] OP_AND = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b1001;
  localparam logic [3:0] OP_CMP = 4'b1011;
  localparam logic [3:0] OP_MOV = 4'b1101;
  // Reg-reg op_ex values reuse the immediate-form opcode values.
  localparam logic [3:0] EX_AND = OP_AND;
  localparam logic [3:0] EX_OR  = OP_OR;
  localparam logic [3:0] EX_XOR = OP_XOR;
  localparam logic [3:0] EX_ADD = OP_ADD;
  localparam logic [3:0] EX_SUB = OP_SUB;
  localparam logic [3:0] EX_CMP = OP_CMP;
  localparam logic [3:0] EX_MOV = OP_MOV;
  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0101;
  localparam logic [3:0] ALU_CMP = 4'b1111;
  localparam logic [3:0] ALU_AND = 4'b1000;
  localparam logic [3:0] ALU_OR  = 4'b1010;
  localparam logic [3:0] ALU_XOR = 4'b0000;
  localparam logic [3:0] ALU_MOV = 4'b0111;
  localparam logic [3:0] ALU_NOP = 4'b0000;
  // The immediate is kept as the raw 8-bit field plus an extension mode so the
  // stored micro-op is independent of the datapath width; extension happens at the output.
  typedef struct packed {
    logic [3:0] alu;
    logic       arith_mux;
    logic [3:0] rdest;
    logic [3:0] rsrc;
    logic [7:0] imm;
    logic       imm_sext;
    logic       wr_en;
    logic       flags_en;
    logic       illegal;
  } uop_t;
  // Returns {legal, alu_code} for an operation code (op or op_ex).
  function automatic logic [4:0] alu_lookup(input logic [3:0] code);
    case (code)
      OP_ADD:  return {1'b1, ALU_ADD};
      OP_SUB:  return {1'b1, ALU_SUB};
      OP_CMP:  return {1'b1, ALU_CMP};
      OP_AND:  return {1'b1, ALU_AND};
      OP_OR:   return {1'b1, ALU_OR};
      OP_XOR:  return {1'b1, ALU_XOR};
      OP_MOV:  return {1'b1, ALU_MOV};
      default: return {1'b0, ALU_NOP};
    endcase
  endfunction
  function automatic logic is_arith(input logic [3:0] code);
    return code == OP_ADD || code == OP_SUB || code == OP_CMP;
  endfunction
endpackage

// File: rtl/ins_decode_comb.sv
// ins_decode_comb: combinational 16-bit instruction to micro-op decoder
//   instruction : op[15:12] rdest[11:8] op_ex[7:4] rsrc/immLow[3:0]
//   uop         : decoded micro-op (raw 8-bit immediate plus extension mode)
module ins_decode_comb
  import cpu16_isa_pkg::*;
#(
  parameter bit SEXT_LOGIC = 1'b0
) (
  input  logic [15:0] instruction,
  output uop_t        uop
);
  logic       rr;
  logic       legal;
  logic [3:0] code;
  logic [3:0] alu;
  always_comb begin
    rr = instruction[15:12] == OP_RR;
    code = rr ? instruction[7:4] : instruction[15:12];
    {legal, alu} = alu_lookup(code);
    uop = '0;
    uop.alu = alu;
    uop.arith_mux = legal && !rr;
    uop.rdest = instruction[11:8];
    uop.rsrc = instruction[3:0];
    uop.imm = (legal && !rr) ? instruction[7:0] : 8'h00;
    uop.imm_sext = is_arith(code) || SEXT_LOGIC;
    uop.wr_en = legal && code != OP_CMP;
    uop.flags_en = legal && is_arith(code);
    uop.illegal = !legal;
  end
endmodule

// File: rtl/ins_decode_stage.sv
// ins_decode_stage: registered valid/ready decode stage with a one-entry skid buffer
//   clk, rst_n (async active-low), flush (sync)
//   in_valid/in_ready/instruction : fetch side
//   out_valid/out_ready           : issue side handshake
//   alu_out, arith_mux, rdest, rsrc, imm, wr_en, flags_en, illegal : decoded micro-op
module ins_decode_stage
  import cpu16_isa_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int REG_AW     = 4,
  parameter bit SEXT_LOGIC = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instruction,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        alu_out,
  output logic              arith_mux,
  output logic [REG_AW-1:0] rdest,
  output logic [REG_AW-1:0] rsrc,
  output logic [DATA_W-1:0] imm,
  output logic              wr_en,
  output logic              flags_en,
  output logic              illegal
);
  uop_t dec_uop;
  uop_t main_q, main_d, skid_q, skid_d;
  logic main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic acc, load_main;
  ins_decode_comb #(.SEXT_LOGIC(SEXT_LOGIC)) u_dec (
    .instruction(instruction),
    .uop        (dec_uop)
  );
  always_comb begin
    acc = in_valid && !skid_v_q;
    // Main can take a new entry when it is empty or being consumed this cycle.
    load_main = !main_v_q || out_ready;
    main_v_d = flush ? 1'b0 : load_main ? (skid_v_q || acc) : 1'b1;
    skid_v_d = flush ? 1'b0 : load_main ? 1'b0 : (skid_v_q || acc);
    main_d = (flush || !load_main) ? main_q : skid_v_q ? skid_q : acc ? dec_uop : main_q;
    skid_d = (!flush && !load_main && acc) ? dec_uop : skid_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end
  assign in_ready = !skid_v_q;
  assign out_valid = main_v_q;
  assign alu_out = main_q.alu;
  assign arith_mux = main_q.arith_mux;
  assign rdest = main_q.rdest[REG_AW-1:0];
  assign rsrc = main_q.rsrc[REG_AW-1:0];
  assign imm = main_q.imm_sext ? DATA_W'($signed(main_q.imm)) : DATA_W'(main_q.imm);
  assign wr_en = main_q.wr_en;
  assign flags_en = main_q.flags_en;
  assign illegal = main_q.illegal;
endmodule

// File: tb/tb_ins_decode_stage.sv
// tb_ins_decode_stage: directed vectors, corner sequences and a random scoreboard run
module tb_ins_decode_stage;
  localparam bit SEXT = 1'b0;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] instruction = 16'h0;
  logic        in_ready, out_valid, arith_mux, wr_en, flags_en, illegal;
  logic [3:0]  alu_out, rdest, rsrc;
  logic [15:0] imm;
  logic [31:0] got;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] q[$];
  typedef struct {
    logic [15:0] ins;
    logic [3:0]  alu;
    logic        mux;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [15:0] imm;
    logic        wr;
    logic        fl;
    logic        ill;
  } vec_t;
  vec_t vecs[11];

  ins_decode_stage #(.DATA_W(16), .REG_AW(4), .SEXT_LOGIC(SEXT)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .out_valid(out_valid), .out_ready(out_ready),
    .alu_out(alu_out), .arith_mux(arith_mux), .rdest(rdest), .rsrc(rsrc), .imm(imm),
    .wr_en(wr_en), .flags_en(flags_en), .illegal(illegal)
  );

  always #5 clk = ~clk;
  assign got = {alu_out, arith_mux, rdest, rsrc, imm, wr_en, flags_en, illegal};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference decode straight from the ISA table; packed like `got`.
  function automatic logic [31:0] ref_dec(input logic [15:0] ins);
    logic [3:0] kind, alu;
    bit ok, imm_form, arith, sx;
    int v;
    imm_form = ins[15:12] != 4'h0;
    kind = imm_form ? ins[15:12] : ins[7:4];
    ok = 1;
    case (kind)
      4'h5: alu = 4'h4;
      4'h9: alu = 4'h5;
      4'hB: alu = 4'hF;
      4'h1: alu = 4'h8;
      4'h2: alu = 4'hA;
      4'h3: alu = 4'h0;
      4'hD: alu = 4'h7;
      default: begin alu = 4'h0; ok = 0; end
    endcase
    arith = kind == 4'h5 || kind == 4'h9 || kind == 4'hB;
    sx = arith || SEXT;
    if (!(ok && imm_form)) v = 0;
    else if (sx) v = int'($signed(ins[7:0]));
    else v = int'(ins[7:0]);
    return {alu, 1'(ok && imm_form), ins[11:8], ins[3:0], v[15:0],
            1'(ok && kind != 4'hB), 1'(ok && arith), 1'(!ok)};
  endfunction

  initial begin
    vecs[0]  = '{16'h0152, 4'h4, 1'b0, 4'h1, 4'h2, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{16'h53F6, 4'h4, 1'b1, 4'h3, 4'h6, 16'hFFF6, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{16'h1AF0, 4'h8, 1'b1, 4'hA, 4'h0, 16'h00F0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{16'hB205, 4'hF, 1'b1, 4'h2, 4'h5, 16'h0005, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{16'h4123, 4'h0, 1'b0, 4'h1, 4'h3, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{16'h0F3E, 4'h0, 1'b0, 4'hF, 4'hE, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{16'h0FF0, 4'h0, 1'b0, 4'hF, 4'h0, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{16'hD780, 4'h7, 1'b1, 4'h7, 4'h0, 16'h0080, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{16'h9480, 4'h5, 1'b1, 4'h4, 4'h0, 16'hFF80, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{16'h2355, 4'hA, 1'b1, 4'h3, 4'h5, 16'h0055, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{16'h3C7F, 4'h0, 1'b1, 4'hC, 4'hF, 16'h007F, 1'b1, 1'b0, 1'b0};
    #3;
    chk("reset_payload", got, 32'h0);
    chk("reset_valid", 32'(out_valid), 32'h0);
    #4 rst_n = 1'b1;
    step();
    chk("ready_after_reset", 32'(in_ready), 32'h1);
    // Directed decode table, back-to-back with the consumer always ready.
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      instruction = vecs[i].ins;
      in_valid = 1'b1;
      step();
      chk("vec_valid", 32'(out_valid), 32'h1);
      chk($sformatf("vec_%h", vecs[i].ins), got,
          {vecs[i].alu, vecs[i].mux, vecs[i].rd, vecs[i].rs, vecs[i].imm,
           vecs[i].wr, vecs[i].fl, vecs[i].ill});
    end
    in_valid = 1'b0;
    step();
    chk("drained", 32'(out_valid), 32'h0);
    // Backpressure into the skid buffer, then release.
    out_ready = 1'b0;
    in_valid = 1'b1;
    instruction = 16'h0152;
    step();
    chk("bp_first", got, ref_dec(16'h0152));
    chk("bp_ready1", 32'(in_ready), 32'h1);
    instruction = 16'h0192;
    step();
    chk("bp_ready2", 32'(in_ready), 32'h0);
    chk("bp_hold1", got, ref_dec(16'h0152));
    instruction = 16'h01B2;
    step();
    chk("bp_hold2", got, ref_dec(16'h0152));
    chk("bp_valid", 32'(out_valid), 32'h1);
    out_ready = 1'b1;
    step();
    chk("bp_second", got, ref_dec(16'h0192));
    chk("bp_ready_back", 32'(in_ready), 32'h1);
    step();
    chk("bp_third", got, ref_dec(16'h01B2));
    chk("bp_third_valid", 32'(out_valid), 32'h1);
    in_valid = 1'b0;
    step();
    chk("bp_empty", 32'(out_valid), 32'h0);
    // Flush with both entries full and an input presented.
    out_ready = 1'b0;
    in_valid = 1'b1;
    instruction = 16'h0152;
    step();
    instruction = 16'h0192;
    step();
    instruction = 16'h01B2;
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 32'(out_valid), 32'h0);
    chk("flush_ready", 32'(in_ready), 32'h1);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("flush_no_stale", 32'(out_valid), 32'h0);
    end
    // Asynchronous reset in the middle of a stall.
    out_ready = 1'b0;
    in_valid = 1'b1;
    instruction = 16'h0192;
    step();
    instruction = 16'hB205;
    step();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("areset_payload", got, 32'h0);
    chk("areset_valid", 32'(out_valid), 32'h0);
    chk("areset_ready", 32'(in_ready), 32'h1);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    instruction = 16'h53F6;
    step();
    chk("post_reset_valid", 32'(out_valid), 32'h1);
    chk("post_reset_uop", got, ref_dec(16'h53F6));
    in_valid = 1'b0;
    step();
    // Random traffic against a queue model of the two-entry stage.
    for (int c = 0; c < 3000; c++) begin
      chk("rnd_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("rnd_ready", 32'(in_ready), 32'(q.size() < 2));
      if (out_valid && q.size() != 0) chk("rnd_payload", got, q[0]);
      in_valid = $urandom_range(0, 3) != 0;
      instruction = 16'($urandom);
      if ($urandom_range(0, 1) == 1) instruction[15:12] = 4'h0;
      out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 49) == 0;
      if (flush) q.delete();
      else begin
        if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
        if (in_valid && in_ready) q.push_back(ref_dec(instruction));
      end
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ins_decode_stage.md
Name: ins_decode_stage

Overview:
- Registered, handshaked successor to the combinational instruction decoder.
- Sits between instruction fetch and the register-file/ALU issue logic. Accepts one 16-bit instruction per cycle on a valid/ready interface.
- Emits a fully decoded micro-op one cycle later: ALU code, operand-mux select, register addresses, extended immediate, write/flag enables and an illegal-instruction flag.
- A one-entry skid buffer absorbs downstream stalls without combinational ready paths.

Parameters:
- DATA_W, 16: datapath width; immediate is extended to this width (must be >= 8).
- REG_AW, 4: register address width taken from the instruction fields (must be <= 4).
- SEXT_LOGIC, 0: 1 = logical-immediate ops (ANDI/ORI/XORI/MOVI) sign-extend; 0 = zero-extend.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  instruction present.
- in_ready  out  1  stage can accept.
- instruction  in  16  op[15:12], rdest[11:8], op_ex[7:4], rsrc/immLow[3:0].
- out_valid  out  1  decoded micro-op present.
- out_ready  in  1  consumer accepts.
- alu_out  out  4  ALU operation code.
- arith_mux  out  1  0 = reg-reg, 1 = reg-imm.
- rdest  out  REG_AW  destination register.
- rsrc  out  REG_AW  source register.
- imm  out  DATA_W  extended immediate from instruction[7:0].
- wr_en  out  1  writes rdest.
- flags_en  out  1  updates PSR flags.
- illegal  out  1  unrecognised encoding.

Behaviour:
- Reset: all outputs low / zero, including out_valid, alu_out, imm and illegal. in_ready is 1 once rst_n is high.
- Decode table, where op=0000 selects reg-reg and op_ex selects the operation:
  - ADD 0101 -> 0100.
  - SUB 1001 -> 0101.
  - CMP 1011 -> 1111.
  - AND 0001 -> 1000.
  - OR 0010 -> 1010.
  - XOR 0011 -> 0000.
  - MOV 1101 -> 0111.
- Reg-reg forms: arith_mux=0 and imm=0.
- Immediate forms use op equal to the same codes (0101, 1001, 1011, 0001, 0010, 0011, 1101) with the same ALU codes and arith_mux=1. For these, instruction[7:0] is the immediate.
- Immediate extension:
  - ADDI/SUBI/CMPI always sign-extend.
  - ANDI/ORI/XORI/MOVI extend per SEXT_LOGIC.
- wr_en=1 for every legal op except CMP/CMPI.
- flags_en=1 for ADD, SUB and CMP (both forms) only.
- Illegal encodings: any other op, or op=0000 with an unlisted op_ex.
  - Output: illegal=1, alu_out=0000, arith_mux=0, wr_en=0, flags_en=0.
  - The micro-op is still delivered with out_valid=1. No latch/hold of a previous code.
- Latency: exactly 1 cycle from an accepted input to out_valid when the stage is empty.
- Transfers: an input transfer occurs when in_valid & in_ready; an output transfer when out_valid & out_ready.
- Storage: output register (main) plus one skid register.
  - in_ready = !skid_valid (registered; no combinational path from out_ready).
  - Input accepted while main is valid and out_ready=0: the input goes to skid.
  - Main consumed while skid is valid: skid moves to main the same cycle, and skid_valid clears.
  - Simultaneous accept and consume with skid empty: the new input goes straight to main.
- Order is preserved; no micro-op is dropped or duplicated.
- out_valid and the payload stay stable while out_ready=0.
- flush: clears main and skid valid bits on the next edge and drops any input presented that cycle. flush has priority over all transfers.
- Reset mid-operation: both entries are discarded asynchronously.

Decomposition:
- Shared package cpu16_isa_pkg holds:
  - opcode constants (OP_RR=0000, OP_ADD=0101, …);
  - op_ex constants;
  - ALU code constants (ALU_ADD=4'b0100, …);
  - a micro-op struct {alu, arith_mux, rdest, rsrc, imm, wr_en, flags_en, illegal}.
- Natural sub-module: ins_decode_comb, a pure combinational instruction -> micro-op decoder. It is instantiated once on the input path, and both registers store decoded micro-ops.

Test Plan:
- Reset, then 0x0152 with out_ready=1 -> next cycle out_valid=1, alu_out=0100, arith_mux=0, rdest=1, rsrc=2, imm=0, wr_en=1, flags_en=1.
- 0x53F6 -> alu_out=0100, arith_mux=1, rdest=3, imm=0xFFF6. Then 0x1AF0 with SEXT_LOGIC=0 -> alu_out=1000, imm=0x00F0, flags_en=0.
- 0xB205 -> alu_out=1111, arith_mux=1, wr_en=0, flags_en=1. Then 0x4123 -> illegal=1, alu_out=0000, wr_en=0.
- Backpressure: stream 0x0152, 0x0192, 0x01B2 with out_ready=0 for 3 cycles.
  - in_ready drops after the second accept.
  - Outputs hold 0x0152's micro-op.
  - On release, 0100, 0101, 1111 arrive in order with no gaps or duplicates.
- flush with main and skid both full -> out_valid=0 next cycle, in_ready=1, no stale micro-op emerges later.
- Assert rst_n low asynchronously mid-stall -> out_valid and all outputs zero immediately. After release, the first new instruction appears with 1-cycle latency.
